parallel_to_serial: RTL and testbench
=====================================

Name: parallel_to_serial

Overview:
- Transmit-side serializer that feeds the serial_to_parallel receiver.
- Accepts WIDTH-bit parallel words through a valid/ready handshake and shifts them out MSB-first, one bit per CLK.
- Whenever no word is offered, it inserts the IDLE_WORD comma (0xBC), so the receiver can always find word alignment.
- After reset it sends a fixed preamble of commas before it accepts any payload.

Parameters:
- WIDTH, 8, word width in bits.
- IDLE_WORD, 8'hBC, comma/filler word sent when idle and during the preamble.
- PREAMBLE_COUNT, 4, number of comma words sent after reset before payload is accepted; legal range ≥1.

Ports:
- CLK  input  1  rising-edge clock; one serial bit per cycle.
- RESET_L  input  1  asynchronous, active-low reset.
- DATA_IN  input  WIDTH  parallel word to transmit.
- VALID_IN  input  1  DATA_IN holds a word to send.
- READY  output  1  the word on DATA_IN is taken at this rising edge if VALID_IN=1.
- DATA_OUT  output  1  serial bit stream, MSB first.
- WORD_START  output  1  high while DATA_OUT carries bit WIDTH-1 of a word.
- IDLE_OUT  output  1  high for every bit of a word that the block inserted as filler.

Behaviour:
- Registers:
  - SHREG[WIDTH-1:0] shift register.
  - BIT_CNT, log2(WIDTH) bits.
  - COMMA_CNT, wide enough for PREAMBLE_COUNT.
  - STATE ∈ {PREAMBLE, ACTIVE}.
  - IDLE_FLAG.
- Reset (RESET_L=0, asynchronous): SHREG=IDLE_WORD, BIT_CNT=0, COMMA_CNT=0, STATE=PREAMBLE, IDLE_FLAG=1.
- Outputs are decoded directly from registers:
  - DATA_OUT=SHREG[WIDTH-1], so it is 1 in reset with the default IDLE_WORD.
  - WORD_START=(BIT_CNT==0), so it is 1 in reset.
  - IDLE_OUT=IDLE_FLAG, so it is 1 in reset.
  - READY=0 in reset.
- READY (combinational) = (BIT_CNT==WIDTH-1) && (STATE==ACTIVE || COMMA_CNT==PREAMBLE_COUNT-1). It is high for exactly 1 cycle per word slot, on the last bit.
- Each rising edge with BIT_CNT≠WIDTH-1: SHREG<=SHREG<<1 (zero fill); BIT_CNT++.
- Rising edge with BIT_CNT==WIDTH-1 (word boundary): BIT_CNT<=0, then:
  - PREAMBLE, COMMA_CNT<PREAMBLE_COUNT-1: COMMA_CNT++, SHREG<=IDLE_WORD, IDLE_FLAG<=1.
  - PREAMBLE, COMMA_CNT==PREAMBLE_COUNT-1: STATE<=ACTIVE, then apply the ACTIVE load rule below.
  - ACTIVE load rule: if VALID_IN=1, SHREG<=DATA_IN and IDLE_FLAG<=0; else SHREG<=IDLE_WORD and IDLE_FLAG<=1.
- Latency: the MSB of an accepted word appears on DATA_OUT in the cycle right after the accepting edge. The word finishes WIDTH cycles later.
- Bit slots are contiguous. The output never stalls and never has a gap between words.
- Handshake:
  - DATA_IN/VALID_IN are sampled only at the READY edge.
  - VALID_IN high in a non-READY cycle has no effect.
  - DATA_IN may change freely outside the READY edge.
- A word is never dropped: VALID_IN=1 at a READY edge always loads.
- Upstream must hold VALID_IN/DATA_IN until it sees READY.
- A payload word equal to IDLE_WORD is sent unchanged with IDLE_OUT=0. Avoiding it is the upstream's responsibility.
- Reset mid-word: the line returns to the reset state immediately; the partial word is abandoned and the full preamble restarts.
- Preamble timing: PREAMBLE_COUNT full comma words are sent starting from reset release. Reset release to first READY is PREAMBLE_COUNT*WIDTH-1 rising edges.

Test Plan:
- Preamble (defaults):
  - Stimulus: hold RESET_L=0 for 2 cycles, release, keep VALID_IN=0.
  - Required: DATA_OUT shows 10111100 ×4, then continues as commas.
  - Required: READY first rises after edge 31 (counting from release) and is high for 1 cycle.
  - Required: WORD_START=1 every 8th cycle; IDLE_OUT=1 throughout.
- Single word:
  - Stimulus: after the preamble, DATA_IN=8'h3D with VALID_IN=1 held until READY.
  - Required: next 8 DATA_OUT bits are 00111101 with IDLE_OUT=0.
  - Required: if VALID_IN is then dropped, 10111100 follows with IDLE_OUT=1.
- Back-to-back:
  - Stimulus: present 8'h0C then 8'h55, each updated at its READY edge.
  - Required: DATA_OUT is 00001100 01010101 contiguous, with no comma between them.
- Valid outside READY:
  - Stimulus: pulse VALID_IN for 3 cycles mid-word, never overlapping READY.
  - Required: no load; the comma continues and IDLE_OUT stays 1.
- Reset mid-word:
  - Stimulus: assert RESET_L=0 asynchronously at bit 3 of payload 8'hF7.
  - Required: DATA_OUT=1, READY=0, WORD_START=1 immediately.
  - Required: after release, 4 full commas are sent again before READY.
- Comma in payload:
  - Stimulus: send DATA_IN=8'hBC as payload.
  - Required: 10111100 is transmitted with IDLE_OUT=0.

Source files
------------

// File: rtl/parallel_to_serial.sv
// Transmit serializer: MSB-first word slots with comma filler and a post-reset
// preamble of commas ahead of any payload.
module parallel_to_serial #(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] IDLE_WORD      = 'hBC,
   parameter int               PREAMBLE_COUNT = 4
) (
   input  logic             CLK,
   input  logic             RESET_L,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             VALID_IN,
   output logic             READY,
   output logic             DATA_OUT,
   output logic             WORD_START,
   output logic             IDLE_OUT
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PRE_W = (PREAMBLE_COUNT > 1) ? $clog2(PREAMBLE_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
   localparam logic [PRE_W-1:0] LAST_COMMA = PRE_W'(PREAMBLE_COUNT - 1);

   localparam logic [0:0] ST_PREAMBLE = 1'b0;
   localparam logic [0:0] ST_ACTIVE   = 1'b1;

   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [PRE_W-1:0] comma_cnt;
   logic [0:0]       state;
   logic             idle_flag;
   logic             word_end;
   logic             accept_slot;

   // The last preamble comma already opens the first payload slot.
   assign word_end    = (bit_cnt == LAST_BIT);
   assign accept_slot = (state == ST_ACTIVE) || (comma_cnt == LAST_COMMA);

   assign READY      = word_end && accept_slot;
   assign DATA_OUT   = shreg[WIDTH-1];
   assign WORD_START = (bit_cnt == '0);
   assign IDLE_OUT   = idle_flag;

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         shreg     <= IDLE_WORD;
         bit_cnt   <= '0;
         comma_cnt <= '0;
         state     <= ST_PREAMBLE;
         idle_flag <= 1'b1;
      end else if (!word_end) begin
         shreg   <= shreg << 1;
         bit_cnt <= bit_cnt + 1'b1;
      end else begin
         bit_cnt <= '0;
         if (accept_slot) begin
            state <= ST_ACTIVE;
            if (VALID_IN) begin
               shreg     <= DATA_IN;
               idle_flag <= 1'b0;
            end else begin
               shreg     <= IDLE_WORD;
               idle_flag <= 1'b1;
            end
         end else begin
            comma_cnt <= comma_cnt + 1'b1;
            shreg     <= IDLE_WORD;
            idle_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized bench for parallel_to_serial: a time-indexed slot model checks
// every cycle, and a word receiver checks the decoded stream end to end.
module tb_parallel_to_serial;

   localparam int         W    = 8;
   localparam int         PC   = 4;
   localparam logic [7:0] IDLE = 8'hBC;

   logic         CLK = 1'b0;
   logic         RESET_L = 1'b1;
   logic [W-1:0] DATA_IN = '0;
   logic         VALID_IN = 1'b0;
   logic         READY, DATA_OUT, WORD_START, IDLE_OUT;

   int n_chk = 0;
   int n_fail = 0;

   parallel_to_serial #(.WIDTH(W), .IDLE_WORD(IDLE), .PREAMBLE_COUNT(PC)) dut (
      .CLK(CLK), .RESET_L(RESET_L), .DATA_IN(DATA_IN), .VALID_IN(VALID_IN),
      .READY(READY), .DATA_OUT(DATA_OUT), .WORD_START(WORD_START), .IDLE_OUT(IDLE_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: t counts bit slots since reset release; slot t/W carries one word.
   int         m_t = 0;
   logic [7:0] m_word = IDLE;
   logic       m_idle = 1'b1;

   always @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         m_t = 0; m_word = IDLE; m_idle = 1'b1;
      end else begin
         if (m_t % W == W - 1) begin
            if (m_t / W >= PC - 1 && VALID_IN) begin
               m_word = DATA_IN; m_idle = 1'b0;
            end else begin
               m_word = IDLE; m_idle = 1'b1;
            end
         end
         m_t++;
      end
   end

   bit mon_en = 0;
   always @(negedge CLK) begin
      if (mon_en) begin
         check("data_out", DATA_OUT, m_word[W - 1 - (m_t % W)]);
         check("word_start", WORD_START, (m_t % W) == 0);
         check("idle_out", IDLE_OUT, m_idle);
         check("ready", READY, (m_t % W == W - 1) && (m_t / W >= PC - 1));
      end
   end

   // Receiver: rebuild {idle, word} entries from the serial line.
   logic [8:0] rx_q[$];
   logic [7:0] rx_sh = '0;
   logic       rx_idle = 1'b0;
   int         rx_n = 0;
   int         rel_edges = 0;
   int         first_ready = -1;

   always @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         rel_edges = 0; first_ready = -1;
      end else rel_edges++;
   end

   always @(negedge CLK) begin
      if (!RESET_L) rx_n = 0;
      else begin
         if (READY && first_ready < 0) first_ready = rel_edges;
         if (WORD_START) begin
            rx_sh = {7'b0, DATA_OUT}; rx_idle = IDLE_OUT; rx_n = 1;
         end else if (rx_n > 0) begin
            rx_sh = {rx_sh[6:0], DATA_OUT}; rx_n++;
            if (rx_n == W) begin
               rx_q.push_back({rx_idle, rx_sh});
               rx_n = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit keep);
      int n = 0;
      DATA_IN = d; VALID_IN = 1'b1;
      while (!READY && n < 100) begin
         @(negedge CLK); n++;
      end
      if (n >= 100) check("ready_timeout", 0, 1);
      @(posedge CLK); #1;
      if (!keep) VALID_IN = 1'b0;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge CLK);
      #1 RESET_L = 1'b1;
      rx_q.delete();
   endtask

   task automatic check_preamble(input string tag);
      repeat (40) @(negedge CLK);
      check({tag, "_first_ready"}, first_ready, 2 * 0 + PC * W - 1);
      check({tag, "_nwords"}, rx_q.size() >= PC, 1);
      for (int i = 0; i < PC && i < rx_q.size(); i++)
         check({tag, "_comma"}, rx_q[i], {1'b1, IDLE});
   endtask

   // Compare entries starting at the first payload word against exp.
   task automatic check_seq(input string tag, input logic [8:0] exp[$]);
      int s = -1;
      for (int i = 0; i < rx_q.size(); i++)
         if (s < 0 && !rx_q[i][8]) s = i;
      check({tag, "_found"}, s >= 0 && s + exp.size() <= rx_q.size(), 1);
      if (s >= 0)
         for (int i = 0; i < exp.size() && s + i < rx_q.size(); i++)
            check({tag, "_word"}, rx_q[s + i], exp[i]);
   endtask

   initial begin
      logic [8:0] exp[$];
      logic [7:0] sent_q[$];
      logic [7:0] got_q[$];
      logic [7:0] d;
      int         payload_cnt;

      #1 RESET_L = 1'b0;
      #1;
      check("rst_data_out", DATA_OUT, 1);
      check("rst_word_start", WORD_START, 1);
      check("rst_idle_out", IDLE_OUT, 1);
      check("rst_ready", READY, 0);
      mon_en = 1;
      release_reset();
      check_preamble("pre");

      rx_q.delete();
      send(8'h3D, 0);
      repeat (20) @(negedge CLK);
      exp = '{{1'b0, 8'h3D}, {1'b1, IDLE}};
      check_seq("single", exp);

      rx_q.delete();
      send(8'h0C, 1);
      send(8'h55, 0);
      repeat (20) @(negedge CLK);
      exp = '{{1'b0, 8'h0C}, {1'b0, 8'h55}, {1'b1, IDLE}};
      check_seq("b2b", exp);

      rx_q.delete();
      while (m_t % W != 2) @(negedge CLK);
      DATA_IN = 8'hA5; VALID_IN = 1'b1;
      repeat (3) @(negedge CLK);
      VALID_IN = 1'b0;
      repeat (24) @(negedge CLK);
      payload_cnt = 0;
      foreach (rx_q[i]) if (!rx_q[i][8]) payload_cnt++;
      check("valid_no_ready_loads", payload_cnt, 0);

      rx_q.delete();
      send(8'hBC, 0);
      repeat (20) @(negedge CLK);
      exp = '{{1'b0, IDLE}, {1'b1, IDLE}};
      check_seq("comma_payload", exp);

      send(8'hF7, 0);
      repeat (4) @(posedge CLK);
      #2;
      check("pre_rst_bit", DATA_OUT, 0);
      RESET_L = 1'b0;
      #1;
      check("midrst_data_out", DATA_OUT, 1);
      check("midrst_ready", READY, 0);
      check("midrst_word_start", WORD_START, 1);
      check("midrst_idle_out", IDLE_OUT, 1);
      release_reset();
      check_preamble("repre");

      // Random traffic with random gaps, including the comma value as payload.
      rx_q.delete();
      repeat (30) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) d = IDLE;
         sent_q.push_back(d);
         send(d, 0);
      end
      repeat (20) @(negedge CLK);
      foreach (rx_q[i]) if (!rx_q[i][8]) got_q.push_back(rx_q[i][7:0]);
      check("rand_count", got_q.size(), sent_q.size());
      for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
         check("rand_word", got_q[i], sent_q[i]);

      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
